// File: rtl/pwm_duty_sequencer_if.sv
// Configuration request channel for the PWM duty sequencer.
// One transfer happens on every rising clk edge where cfg_valid and
// cfg_ready are both high.
//   cfg_valid : request valid (master -> slave)
//   cfg_ready : sequencer can accept a request (slave -> master)
//   cfg_ch    : target channel 0..2; 3 is illegal
//   cfg_duty  : requested duty, clamped to DUTY_MAX by the sequencer
//   cfg_mode  : requested mode, 0 = 960 Hz, 1 = 50 Hz servo
interface pwm_duty_sequencer_if #(
  parameter int DUTY_W = 7
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DUTY_W-1:0] cfg_duty;
  logic              cfg_mode;

  modport master (
    output cfg_valid, cfg_ch, cfg_duty, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_duty, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Control-plane sequencer in front of the three-channel PWM comparator.
// Owns the live duty and mode inputs of the datapath: requested duties are
// reached by ramping one STEP per PWM period, and a mode change first drains
// every channel to 0, flips the mode on a period boundary, then ramps back.
// Ports:
//   clk         : system clock (10 MHz)
//   rst_n       : asynchronous reset, active HIGH (legacy name kept)
//   period_tick : one-cycle pulse at each PWM period start
//   cfg         : request channel (slave side of pwm_duty_sequencer_if)
//   duty_out    : live duties, ch0 in the least significant DUTY_W bits
//   mode_out    : live mode to the prescaler/comparator
//   busy        : high whenever a ramp or drain is in progress
//   err         : one-cycle pulse after an illegal-channel request
module pwm_duty_sequencer #(
  parameter int NCH      = 3,
  parameter int DUTY_W   = 7,
  parameter int STEP     = 1,
  parameter int DUTY_MAX = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  period_tick,
  pwm_duty_sequencer_if.slave   cfg,
  output logic [NCH*DUTY_W-1:0] duty_out,
  output logic                  mode_out,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, RAMP, DRAIN} state_t;
  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t STEP_D = duty_t'(STEP);
  localparam duty_t MAX_D  = duty_t'(DUTY_MAX);

  state_t state, state_n;
  duty_t  duty   [NCH];
  duty_t  duty_n [NCH];
  duty_t  target   [NCH];
  duty_t  target_n [NCH];
  logic   pending_mode, pending_n;
  logic   mode_n, err_n;
  logic   xfer, legal, all_zero, settled;

  // Move cur toward tgt by at most STEP, landing exactly on tgt.
  function automatic duty_t step_toward(duty_t cur, duty_t tgt);
    if (cur < tgt) return (tgt - cur > STEP_D) ? cur + STEP_D : tgt;
    if (cur > tgt) return (cur - tgt > STEP_D) ? cur - STEP_D : tgt;
    return cur;
  endfunction

  // Ready and busy are pure decodes of the state register, so they are
  // glitch-free and carry no path from the request inputs.
  assign cfg.cfg_ready = (state != DRAIN);
  assign busy          = (state != IDLE);
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign legal         = (32'(cfg.cfg_ch) < NCH);

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign duty_out[g*DUTY_W +: DUTY_W] = duty[g];
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_n   = state;
    mode_n    = mode_out;
    pending_n = pending_mode;
    err_n     = 1'b0;
    all_zero  = 1'b1;
    settled   = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      duty_n[i]   = duty[i];
      target_n[i] = target[i];
      if (duty[i] != '0) all_zero = 1'b0;
    end

    // Period-boundary duty movement; always uses the targets held before
    // any transfer in this same cycle.
    case (state)
      RAMP: begin
        if (period_tick) begin
          for (int i = 0; i < NCH; i++) duty_n[i] = step_toward(duty[i], target[i]);
        end
      end
      DRAIN: begin
        if (period_tick) begin
          if (all_zero) begin
            mode_n  = pending_mode;
            state_n = RAMP;
          end else begin
            for (int i = 0; i < NCH; i++)
              duty_n[i] = (duty[i] > STEP_D) ? duty[i] - STEP_D : '0;
          end
        end
      end
      default: ;
    endcase

    if (xfer && !legal) err_n = 1'b1;

    if (xfer && legal) begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg.cfg_ch == 2'(i)) target_n[i] = (cfg.cfg_duty > MAX_D) ? MAX_D : cfg.cfg_duty;
      end
    end

    for (int i = 0; i < NCH; i++) begin
      if (duty_n[i] != target_n[i]) settled = 1'b0;
    end

    // A mode change wins over ramping; otherwise the ramp runs until every
    // channel sits on its target.
    if (xfer && legal) begin
      if (cfg.cfg_mode != mode_out) begin
        pending_n = cfg.cfg_mode;
        state_n   = DRAIN;
      end else begin
        state_n = settled ? IDLE : RAMP;
      end
    end else if (state == RAMP && period_tick) begin
      state_n = settled ? IDLE : RAMP;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      mode_out     <= 1'b0;
      pending_mode <= 1'b0;
      err          <= 1'b0;
      // NOTE: the duty/target arrays are a handful of flops, not RAM, so
      // they are reset explicitly to give the datapath a known 0 duty.
      for (int i = 0; i < NCH; i++) begin
        duty[i]   <= '0;
        target[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values, independent of statement order.
      state        <= state_n;
      mode_out     <= mode_n;
      pending_mode <= pending_n;
      err          <= err_n;
      for (int i = 0; i < NCH; i++) begin
        duty[i]   <= duty_n[i];
        target[i] <= target_n[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// tracks duties, targets and the ramp/drain activity with integer arithmetic.
module tb_pwm_duty_sequencer;
  localparam int NCH      = 3;
  localparam int DUTY_W   = 7;
  localparam int STEP     = 1;
  localparam int DUTY_MAX = 100;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  period_tick;
  logic [NCH*DUTY_W-1:0] duty_out;
  logic                  mode_out, busy, err;

  pwm_duty_sequencer_if #(.DUTY_W(DUTY_W)) cfg ();

  pwm_duty_sequencer #(
    .NCH(NCH), .DUTY_W(DUTY_W), .STEP(STEP), .DUTY_MAX(DUTY_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .period_tick(period_tick), .cfg(cfg),
    .duty_out(duty_out), .mode_out(mode_out), .busy(busy), .err(err)
  );

  always #50 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state.
  int md[NCH];
  int mt[NCH];
  bit m_mode, m_pend, m_ramp, m_drain, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] model_vec();
    return {7'(md[2]), 7'(md[1]), 7'(md[0]), m_mode, m_ramp | m_drain, m_err, ~m_drain};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {duty_out, mode_out, busy, err, cfg.cfg_ready};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      md[i] = 0;
      mt[i] = 0;
    end
    m_mode = 0; m_pend = 0; m_ramp = 0; m_drain = 0; m_err = 0;
  endtask

  function automatic bit off_target(input int nd[NCH]);
    for (int i = 0; i < NCH; i++) if (nd[i] != mt[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input bit tick, input bit xfer, input int ch, input int d, input bit m);
    int nd[NCH];
    int delta;
    bit was_ramp;
    was_ramp = m_ramp;
    for (int i = 0; i < NCH; i++) nd[i] = md[i];
    m_err = 0;
    if (tick && m_ramp) begin
      for (int i = 0; i < NCH; i++) begin
        delta = mt[i] - md[i];
        if (delta > STEP)  delta = STEP;
        if (delta < -STEP) delta = -STEP;
        nd[i] = md[i] + delta;
      end
    end else if (tick && m_drain) begin
      if (md[0] + md[1] + md[2] == 0) begin
        m_mode  = m_pend;
        m_drain = 0;
        m_ramp  = 1;
      end else begin
        for (int i = 0; i < NCH; i++) nd[i] = md[i] - ((md[i] < STEP) ? md[i] : STEP);
      end
    end
    if (xfer && ch >= NCH) m_err = 1;
    if (xfer && ch < NCH) begin
      mt[ch] = (d > DUTY_MAX) ? DUTY_MAX : d;
      if (m != m_mode) begin
        m_pend  = m;
        m_drain = 1;
        m_ramp  = 0;
      end else begin
        m_ramp = off_target(nd);
      end
    end else if (tick && was_ramp) begin
      m_ramp = off_target(nd);
    end
    for (int i = 0; i < NCH; i++) md[i] = nd[i];
  endtask

  // One clock cycle: drive after the falling edge, let the rising edge act,
  // compare everything on the next falling edge.
  task automatic cyc(input bit tick, input bit v = 1'b0, input logic [1:0] ch = 2'd0,
                     input logic [6:0] d = 7'd0, input bit m = 1'b0);
    bit x;
    period_tick   = tick;
    cfg.cfg_valid = v;
    cfg.cfg_ch    = ch;
    cfg.cfg_duty  = d;
    cfg.cfg_mode  = m;
    x = v && !m_drain;
    @(posedge clk);
    model_update(tick, x, int'(ch), int'(d), m);
    @(negedge clk);
    period_tick   = 1'b0;
    cfg.cfg_valid = 1'b0;
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  initial begin
    bit       r_tick, r_v, r_m;
    logic [1:0] r_ch;
    logic [6:0] r_d;

    rst_n = 1'b1;
    period_tick = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = 2'd0;
    cfg.cfg_duty = 7'd0;
    cfg.cfg_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'({21'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
    rst_n = 1'b0;
    cyc(0);

    // Ramp ch1 0 -> 5.
    cyc(0, 1, 2'd1, 7'd5, 0);
    check("t1_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("t1_ch1", 32'({mode_out, duty_out[13:7]}), 32'({1'b0, 7'(k)}));
      if (k == 4) check("t1_busy_mid", 32'(busy), 32'd1);
    end
    check("t1_idle", 32'(busy), 32'd0);

    // Clamp: 120 requested, 100 reached, never exceeded.
    cyc(0, 1, 2'd0, 7'd120, 0);
    for (int k = 1; k <= 100; k++) begin
      cyc(1);
      check("t2_ch0", 32'({err, duty_out[6:0]}), 32'({1'b0, 7'(k)}));
    end
    cyc(1);
    check("t2_hold", 32'({busy, err, duty_out[6:0]}), 32'({1'b0, 1'b0, 7'd100}));

    // Bring ch0/ch1 to 0 and ch2 to 4, then request mode 1.
    cyc(0, 1, 2'd0, 7'd0, 0);
    cyc(0, 1, 2'd1, 7'd0, 0);
    repeat (100) cyc(1);
    cyc(0, 1, 2'd2, 7'd4, 0);
    repeat (4) cyc(1);
    check("t3_prep", 32'({busy, duty_out}), 32'({1'b0, 7'd4, 7'd0, 7'd0}));
    cyc(0, 1, 2'd2, 7'd4, 1);
    check("t3_ready", 32'({busy, cfg.cfg_ready}), 32'({1'b1, 1'b0}));
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("t3_drain", 32'({mode_out, duty_out[20:14]}), 32'({1'b0, 7'(4 - k)}));
    end
    cyc(1);
    check("t3_flip", 32'({mode_out, duty_out[20:14], cfg.cfg_ready}), 32'({1'b1, 7'd0, 1'b1}));
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("t3_ramp", 32'({mode_out, duty_out[20:14]}), 32'({1'b1, 7'(k)}));
    end
    check("t3_idle", 32'(busy), 32'd0);

    // Retarget on a non-tick cycle.
    cyc(0, 1, 2'd0, 7'd10, 1);
    repeat (6) cyc(1);
    check("t4_at6", 32'(duty_out[6:0]), 32'd6);
    cyc(0, 1, 2'd0, 7'd3, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("t4_down", 32'(duty_out[6:0]), 32'(5 - k));
    end
    check("t4_idle", 32'(busy), 32'd0);

    // Retarget on a tick cycle: that tick still heads for the old target.
    cyc(0, 1, 2'd0, 7'd10, 1);
    repeat (3) cyc(1);
    check("t4b_at6", 32'(duty_out[6:0]), 32'd6);
    cyc(1, 1, 2'd0, 7'd3, 1);
    check("t4b_tick_step", 32'(duty_out[6:0]), 32'd7);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("t4b_down", 32'(duty_out[6:0]), 32'(6 - k));
    end
    check("t4b_idle", 32'(busy), 32'd0);

    // Illegal channel, with a differing mode that must not start a drain.
    cyc(0, 1, 2'd3, 7'd55, 0);
    check("t5_err", 32'({err, busy, mode_out, duty_out}),
          32'({1'b1, 1'b0, 1'b1, 7'd4, 7'd0, 7'd3}));
    cyc(0);
    check("t5_err_clear", 32'({err, busy, duty_out}), 32'({1'b0, 1'b0, 7'd4, 7'd0, 7'd3}));
    // Illegal request on a ramp tick: ramp continues unaffected.
    cyc(0, 1, 2'd0, 7'd10, 1);
    cyc(1);
    cyc(1, 1, 2'd3, 7'd0, 1);
    check("t5_err_ramp", 32'({err, duty_out[6:0]}), 32'({1'b1, 7'd5}));
    repeat (5) cyc(1);
    check("t5_ramp_done", 32'({busy, duty_out[6:0]}), 32'({1'b0, 7'd10}));

    // Back to mode 0, then async reset in the middle of a drain.
    cyc(0, 1, 2'd0, 7'd2, 0);
    repeat (16) cyc(1);
    check("t6_prep", 32'({busy, mode_out, duty_out}), 32'({1'b0, 1'b0, 7'd4, 7'd0, 7'd2}));
    cyc(0, 1, 2'd1, 7'd9, 1);
    cyc(1);
    check("t6_draining", 32'({busy, cfg.cfg_ready, duty_out}), 32'({1'b1, 1'b0, 7'd3, 7'd0, 7'd1}));
    #10 rst_n = 1'b1;
    #1;
    model_reset();
    check("t6_async_reset", 32'(dut_vec()), 32'({21'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
    #10 rst_n = 1'b0;
    @(negedge clk);
    cyc(1);
    check("t6_after_tick", 32'({busy, mode_out, duty_out}), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r_tick = ($urandom % 4) == 0;
      r_v    = ($urandom % 3) == 0;
      r_ch   = 2'($urandom % 4);
      r_d    = 7'($urandom % 128);
      r_m    = (($urandom % 40) == 0) ? ~m_mode : m_mode;
      cyc(r_tick, r_v, r_ch, r_d, r_m);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
